alloc_arb: RTL

- Two-client request arbiter sitting directly upstream of the linked-memory allocator `alloc`.
- Each client issues READ/WRITE/ALLOC/FREE over valid/ready.
- The arbiter serialises requests so the allocator never sees a pointer-port op and a memory-port op in the same cycle.
- It routes the allocator's next-cycle results back to the issuing client through a held response register, and halts permanently on allocator error.

---
 rtl/alloc_pkg.sv | 24 ++
 rtl/alloc_arb_slot.sv | 58 +++++
 rtl/alloc_arb.sv | 128 ++++++++++++
 3 files changed

// File: rtl/alloc_pkg.sv
// Shared opcodes, value constants and type-tag masks for the allocator and its arbiter.
package alloc_pkg;
   localparam int DATA_SZ_DEF = 16;
   localparam int NCLI_DEF    = 2;

   localparam logic [1:0] OP_READ  = 2'd0;
   localparam logic [1:0] OP_WRITE = 2'd1;
   localparam logic [1:0] OP_ALLOC = 2'd2;
   localparam logic [1:0] OP_FREE  = 2'd3;

   localparam logic [15:0] UNDEF = 16'h0000;
   localparam logic [15:0] NIL   = 16'h0000;
   localparam logic [15:0] FALSE = 16'h0000;
   localparam logic [15:0] TRUE  = 16'h0001;
   localparam logic [15:0] UNIT  = 16'h0002;
   localparam logic [15:0] ZERO  = 16'h0000;

   localparam logic [15:0] DIR = 16'h8000;
   localparam logic [15:0] MUT = 16'h4000;
   localparam logic [15:0] OPQ = 16'h2000;
   localparam logic [15:0] VLT = 16'h1000;

   typedef enum logic {ST_RUN = 1'b0, ST_HALT = 1'b1} state_e;
endpackage

// File: rtl/alloc_arb_slot.sv
// Per-client inflight flag and held response register; result captured one cycle after the grant.
module alloc_arb_slot import alloc_pkg::*; #(
   parameter int DATA_SZ = DATA_SZ_DEF
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic               i_grant,
   input  logic [1:0]         i_op,
   input  logic               i_alloc_err,
   input  logic [DATA_SZ-1:0] i_alloc_addr,
   input  logic [DATA_SZ-1:0] i_rdata,
   input  logic               i_rsp_ready,
   output logic               o_inflight,
   output logic               o_rsp_valid,
   output logic [DATA_SZ-1:0] o_rsp_data
);
   logic [1:0]         r_op;
   logic               r_inflight;
   logic               r_rsp_valid;
   logic [DATA_SZ-1:0] r_rsp_data;
   logic [DATA_SZ-1:0] w_result;

   always_comb begin
      w_result = DATA_SZ'(UNDEF);
      case (r_op)
         OP_ALLOC: w_result = i_alloc_addr;
         OP_READ:  w_result = i_rdata;
         default:  w_result = DATA_SZ'(UNDEF);
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_op        <= OP_READ;
         r_inflight  <= 1'b0;
         r_rsp_valid <= 1'b0;
         r_rsp_data  <= '0;
      end else begin
         if (i_grant) begin
            r_inflight <= 1'b1;
            r_op       <= i_op;
         end else if (r_inflight) begin
            r_inflight <= 1'b0;
         end
         // A completing op beats a same-edge consume; an erroring op is dropped.
         if (r_inflight && !i_alloc_err) begin
            r_rsp_valid <= 1'b1;
            r_rsp_data  <= w_result;
         end else if (i_rsp_ready) begin
            r_rsp_valid <= 1'b0;
         end
      end
   end

   assign o_inflight  = r_inflight;
   assign o_rsp_valid = r_rsp_valid;
   assign o_rsp_data  = r_rsp_data;
endmodule

// File: rtl/alloc_arb.sv
// Round-robin two-client arbiter in front of the allocator, grant->rsp_valid 2 cycles, sticky halt on error.
// A client holding an unconsumed response is not granted; ALLOC_ARB_PAIR_EN grants an ALLOC+FREE pair together.
module alloc_arb import alloc_pkg::*; #(
   parameter int DATA_SZ = DATA_SZ_DEF,
   parameter int NCLI    = NCLI_DEF
) (
   input  logic                    i_clk,
   input  logic                    i_rst_n,
   input  logic [NCLI-1:0]         i_req_valid,
   output logic [NCLI-1:0]         o_req_ready,
   input  logic [2*NCLI-1:0]       i_req_op,
   input  logic [NCLI*DATA_SZ-1:0] i_req_addr,
   input  logic [NCLI*DATA_SZ-1:0] i_req_data,
   output logic [NCLI-1:0]         o_rsp_valid,
   input  logic [NCLI-1:0]         i_rsp_ready,
   output logic [NCLI*DATA_SZ-1:0] o_rsp_data,
   output logic                    o_alloc,
   output logic [DATA_SZ-1:0]      o_data,
   output logic                    o_free,
   output logic [DATA_SZ-1:0]      o_addr,
   output logic                    o_wr,
   output logic [DATA_SZ-1:0]      o_waddr,
   output logic [DATA_SZ-1:0]      o_wdata,
   output logic                    o_rd,
   output logic [DATA_SZ-1:0]      o_raddr,
   input  logic [DATA_SZ-1:0]      i_alloc_addr,
   input  logic [DATA_SZ-1:0]      i_rdata,
   input  logic                    i_alloc_err,
   output logic                    o_halt
);
   state_e             r_state;
   logic               r_rr;
   logic [NCLI-1:0]    w_elig, w_grant, w_inflight;
   logic               w_run, w_pair, w_sel, w_acli;
   logic [1:0]         w_op0, w_op1, w_sel_op;
   logic [DATA_SZ-1:0] w_addr0, w_addr1, w_data0, w_data1, w_sel_addr, w_sel_data;

   // Gating with the raw reset keeps every grant low while reset is held.
   assign w_run   = (r_state == ST_RUN) && i_rst_n;
   assign w_op0   = i_req_op[1:0];
   assign w_op1   = i_req_op[3:2];
   assign w_addr0 = i_req_addr[DATA_SZ-1:0];
   assign w_addr1 = i_req_addr[2*DATA_SZ-1:DATA_SZ];
   assign w_data0 = i_req_data[DATA_SZ-1:0];
   assign w_data1 = i_req_data[2*DATA_SZ-1:DATA_SZ];

   for (genvar c = 0; c < NCLI; c++) begin : g_cli
      assign w_elig[c] = w_run && i_req_valid[c] && !w_inflight[c] &&
                         (!o_rsp_valid[c] || i_rsp_ready[c]);

      alloc_arb_slot #(.DATA_SZ(DATA_SZ)) u_slot (
         .i_clk        (i_clk),
         .i_rst_n      (i_rst_n),
         .i_grant      (w_grant[c]),
         .i_op         (i_req_op[2*c +: 2]),
         .i_alloc_err  (i_alloc_err),
         .i_alloc_addr (i_alloc_addr),
         .i_rdata      (i_rdata),
         .i_rsp_ready  (i_rsp_ready[c]),
         .o_inflight   (w_inflight[c]),
         .o_rsp_valid  (o_rsp_valid[c]),
         .o_rsp_data   (o_rsp_data[c*DATA_SZ +: DATA_SZ])
      );
   end

`ifdef ALLOC_ARB_PAIR_EN
   assign w_pair = &w_elig && (((w_op0 == OP_ALLOC) && (w_op1 == OP_FREE)) ||
                               ((w_op0 == OP_FREE)  && (w_op1 == OP_ALLOC)));
`else
   assign w_pair = 1'b0;
`endif

   always_comb begin
      w_grant = '0;
      if (w_pair)              w_grant = '1;
      else if (w_elig[r_rr])   w_grant[r_rr] = 1'b1;
      else if (w_elig[~r_rr])  w_grant[~r_rr] = 1'b1;
   end

   assign o_req_ready = w_grant;
   assign w_sel       = w_grant[1];
   assign w_acli      = (w_op1 == OP_ALLOC);
   assign w_sel_op    = w_sel ? w_op1   : w_op0;
   assign w_sel_addr  = w_sel ? w_addr1 : w_addr0;
   assign w_sel_data  = w_sel ? w_data1 : w_data0;

   always_comb begin
      o_alloc = 1'b0;
      o_data  = '0;
      o_free  = 1'b0;
      o_addr  = '0;
      o_wr    = 1'b0;
      o_waddr = '0;
      o_wdata = '0;
      o_rd    = 1'b0;
      o_raddr = '0;
      if (w_pair) begin
         o_alloc = 1'b1;
         o_data  = w_acli ? w_data1 : w_data0;
         o_free  = 1'b1;
         o_addr  = w_acli ? w_addr0 : w_addr1;
      end else if (|w_grant) begin
         case (w_sel_op)
            OP_READ:  begin o_rd = 1'b1;    o_raddr = w_sel_addr; end
            OP_WRITE: begin o_wr = 1'b1;    o_waddr = w_sel_addr; o_wdata = w_sel_data; end
            OP_ALLOC: begin o_alloc = 1'b1; o_data  = w_sel_data; end
            default:  begin o_free = 1'b1;  o_addr  = w_sel_addr; end
         endcase
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= ST_RUN;
         r_rr    <= 1'b0;
      end else begin
         case (r_state)
            ST_RUN: begin
               if (i_alloc_err) r_state <= ST_HALT;
               if (!w_pair && |w_grant) r_rr <= ~w_sel;
            end
            default: r_state <= ST_HALT;
         endcase
      end
   end

   assign o_halt = (r_state == ST_HALT);
endmodule
